// File: rtl/sync_fifo_pkg.sv
// Sizing helpers and parameter checks shared by the sync_fifo_param slice.
// Pointers and the level counter carry one bit beyond the RAM address.
package sync_fifo_pkg;

  localparam int DATA_WIDTH_MAX = 1152;
  localparam int ADDR_WIDTH_MIN = 4;
  localparam int ADDR_WIDTH_MAX = 20;

  function automatic int lvl_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic bit params_ok(
    input int dw,
    input int aw,
    input int af,
    input int ae
  );
    return dw >= 1 && dw <= DATA_WIDTH_MAX
        && aw >= ADDR_WIDTH_MIN
        && aw <= ADDR_WIDTH_MAX
        && af >= 0 && af <= fifo_depth(aw)
        && ae >= 0 && ae <= fifo_depth(aw);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port DEPTH x DATA_WIDTH memory with a registered read port.
// Only the read register is reset so the array still maps onto block RAM.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: level, almost flags, pulses, flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int OUTPUT_REG = 0,
  parameter int AF_RESET   = 1020,
  parameter int AE_RESET   = 940
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic                  underflow,
  input  logic [ADDR_WIDTH:0]   af_num,
  input  logic [ADDR_WIDTH:0]   ae_num,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PW    = lvl_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE_P   = ptr_t'(1);

  if (!params_ok(DATA_WIDTH, ADDR_WIDTH,
                 AF_RESET, AE_RESET)) begin : g_bad_cfg
    $error("sync_fifo_param: illegal parameters");
  end

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t level_q, level_d;
  logic full_q, empty_q, empty_d;
  logic af_q, ae_q, ov_q, uf_q;
  logic wr_acc, rd_acc, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc = wr_en && !full_q && !clr;
  assign rd_acc = rd_en && !empty_q && !clr;

`ifdef SYNC_FIFO_FWFT_EN
  // rd_empty doubles as "head slot free"; refill it whenever it drains.
  assign ram_re  = (wptr_q != rptr_q) && (empty_q || rd_acc) && !clr;
  assign empty_d = clr || !(ram_re || (!empty_q && !rd_acc));
`else
  assign ram_re  = rd_acc;
  assign empty_d = (level_d == '0);
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ONE_P;
      if (ram_re) rptr_d = rptr_q + ONE_P;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign level_d = wptr_d - rptr_d
                 + {{ADDR_WIDTH{1'b0}}, !empty_d};
`else
  assign level_d = wptr_d - rptr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= (level_d == DEPTH_P);
      empty_q <= empty_d;
      af_q    <= (level_d >= af_num);
      ae_q    <= (level_d <= ae_num);
      ov_q    <= wr_en && full_q && !clr;
      uf_q    <= rd_en && empty_q && !clr;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = ram_rdata;
`else
  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        dout_q <= '0;
      end else begin
        vld_q <= rd_acc;
        if (vld_q) dout_q <= ram_rdata;
      end
    end

    assign rd_data = dout_q;
  end else begin : g_noreg
    assign rd_data = ram_rdata;
  end
`endif

  assign wr_full      = full_q;
  assign rd_empty     = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ov_q;
  assign underflow    = uf_q;
  assign level        = level_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO for the ETH_UDP datapath.
- Generalises the fixed 2048x32 FIFO: configurable width and depth, runtime-programmable almost thresholds, a fill-level output, overflow/underflow pulses and a synchronous flush.
- Buffers UDP payload words between the MAC-side packer and the video loop logic.

Parameters:
- DATA_WIDTH, 32, word width in bits (1..1152).
- ADDR_WIDTH, 11, log2 of depth; DEPTH = 2**ADDR_WIDTH (4..20).
- OUTPUT_REG, 0, 1 adds an output register; read latency goes from 1 to 2 cycles.
- AF_RESET, 1020, reset value of the almost-full threshold.
- AE_RESET, 940, reset value of the almost-empty threshold.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush.
- wr_data  in  DATA_WIDTH  write word.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO full.
- almost_full  out  1  level >= af_num.
- overflow  out  1  one-cycle pulse: write request rejected.
- rd_en  in  1  read request / pop.
- rd_data  out  DATA_WIDTH  read word.
- rd_empty  out  1  FIFO empty.
- almost_empty  out  1  level <= ae_num.
- underflow  out  1  one-cycle pulse: read request rejected.
- af_num  in  ADDR_WIDTH+1  almost-full threshold; sampled every cycle.
- ae_num  in  ADDR_WIDTH+1  almost-empty threshold.
- level  out  ADDR_WIDTH+1  current word count, 0..DEPTH.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: wr_full=0, almost_full=0, overflow=0, rd_empty=1, almost_empty=1, underflow=0, level=0, rd_data=0, pointers=0.
- Pointers: ADDR_WIDTH+1 bits, so full and empty are distinguishable by the MSB. Wrap-around is modulo 2*DEPTH, with no special case at the boundary.
- Accept rules:
  - Write accepted iff wr_en && !wr_full.
  - Read accepted iff rd_en && !rd_empty.
  - Flags are registered and reflect level after the current cycle's accepts.
- Simultaneous accepted read and write: level unchanged, both pointers advance.
- When full: rd_en+wr_en → read accepted, write rejected, overflow=1; next cycle level=DEPTH-1.
- When empty: rd_en+wr_en → write accepted, read rejected, underflow=1; next cycle level=1.
- Read latency:
  - OUTPUT_REG=0: rd_data valid 1 cycle after the accepted read.
  - OUTPUT_REG=1: valid 2 cycles after.
  - rd_data holds its last value when no read is accepted.
- Write-to-read: a word written at cycle N is readable (rd_empty=0) at N+1. No read-during-write bypass is needed.
- Threshold compares: use the registered next level, unsigned, ADDR_WIDTH+1 bits.
  - af_num=0 gives almost_full=1 always.
  - ae_num>=DEPTH gives almost_empty=1 always.
- overflow/underflow: single-cycle registered pulses, asserted the cycle after the rejected request.
- clr flush:
  - Next cycle: pointers=0, level=0, rd_empty=1, almost flags recomputed.
  - Any wr_en/rd_en in the clr cycle is ignored and raises no overflow/underflow.
  - RAM contents and rd_data are not cleared.
- rst_n asserted mid-operation: immediate return to reset values; in-flight output-register data is discarded.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - The head word appears on rd_data while rd_empty=0.
  - rd_en acts as an acknowledge/pop: the next word appears in the following cycle if available.
  - A first write into an empty FIFO at cycle N gives rd_empty=0 with valid rd_data at N+2.
  - level includes the prefetched word.
  - OUTPUT_REG is ignored.
- Undefined: standard mode exactly as above; no prefetch logic is synthesised.

Decomposition:
- Package sync_fifo_pkg:
  - level/pointer width function (ADDR_WIDTH+1).
  - localparam DEPTH derivation.
  - parameter-legality checks (thresholds <= DEPTH).
- Sub-module sync_fifo_ram:
  - Simple dual-port memory, DEPTH x DATA_WIDTH.
  - Write port: clk, we, waddr, wdata. Read port: re, raddr, registered rdata (1-cycle).
  - Inferable as block RAM.
- Top level: pointers, level counter, flags, optional output register, FWFT prefetch.

Test Plan:
Bench config: DATA_WIDTH=32, ADDR_WIDTH=4 (DEPTH=16), af_num=12, ae_num=3.
- Fill/drain: write 0xFFFFFFFF down to 0xFFFFFFF0 (16 words) → wr_full=1 after the 16th write, level=16. Read 16 words → same sequence in order at 1-cycle latency; rd_empty=1, level=0.
- Thresholds:
  - After 12 writes → almost_full=1; at 11 → 0.
  - Reading down to level 3 → almost_empty=1; at 4 → 0.
  - Change af_num to 8 at level 10 → almost_full=1 next cycle.
- Over/underflow:
  - Write while full → overflow pulse for 1 cycle, level stays 16, data unchanged.
  - Read while empty → underflow pulse, rd_data unchanged.
- Simultaneous ops:
  - At level 16, rd_en+wr_en → level 15, overflow=1.
  - At level 0 → level 1, underflow=1.
  - At level 7 → level 7, no pulses.
- Pointer wrap: 100 cycles of continuous rd_en+wr_en at level 5 → data order preserved across 6 pointer wraps, no flag glitches.
- Flush/reset: clr at level 9 with wr_en=1 → level 0, rd_empty=1, no overflow. rst_n low mid-burst → all outputs at reset values asynchronously. Repeat with OUTPUT_REG=1 (latency 2) and with SYNC_FIFO_FWFT_EN (head at N+2).
